// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store control unit: size codes, FSM states, helpers.
// No logic of its own; imported by lsu_ctrl and lsu_load_extend.
// Helpers are pure combinational functions.
package lsu_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ONE   = 2'b01,
    ST_SPLIT = 2'b10,
    ST_DONE  = 2'b11
  } lsu_state_t;

  // Natural alignment check; only the two low address bits ever matter.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_WORD: ok = (addr_lo == 2'b00);
      SZ_HALF: ok = (addr_lo[0] == 1'b0);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Pick byte lane idx out of a little-endian 32-bit word.
  function automatic logic [7:0] byte_lane(input logic [31:0] d, input logic [1:0] idx);
    return d[8*idx +: 8];
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load result formatter: assembled little-endian data -> sign/zero-extended 32-bit result.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_result
);

  // Extend from bit 15 (half) or bit 7 (byte); words pass through untouched.
  always_comb begin
    o_result = i_data;
    case (i_size)
      SZ_HALF: o_result = {{16{i_signed & i_data[15]}}, i_data[15:0]};
      SZ_BYTE: o_result = {{24{i_signed & i_data[7]}}, i_data[7:0]};
      default: o_result = i_data;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: one request at a time, aligned ops in one memory cycle, misaligned split to bytes.
// Latency: aligned 2 cycles, misaligned half 3, misaligned word 5, illegal size 1 (accept edge to response).
// Backpressure: req_ready is high only in IDLE; a request is held off until the previous response has gone.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_size,
  output logic              mem_signed,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        r_state;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_cnt;
  logic [31:0]       r_data;

  logic              r_req_ready;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_err;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [1:0]        r_mem_size;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic [1:0]        w_next_cnt;
  logic              w_last;
  logic [31:0]       w_assembled;
  logic [31:0]       w_ext;

  assign w_next_cnt = r_cnt + 2'd1;
  assign w_last     = (r_size == SZ_WORD) ? (r_cnt == 2'd3) : (r_cnt == 2'd1);

  // Load data as it stands at the end of this cycle: whole word for ONE, current byte merged in for SPLIT.
  always_comb begin
    w_assembled = r_data;
    if (r_state == ST_ONE) begin
      w_assembled = mem_rdata;
    end else if (r_state == ST_SPLIT) begin
      w_assembled[8*r_cnt +: 8] = mem_rdata[7:0];
    end
  end

  lsu_load_extend u_ext (
    .i_data   (w_assembled),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_result (w_ext)
  );

  // Control FSM; every output is a register so memory controls are stable for the whole cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_write      <= 1'b0;
      r_size       <= SZ_WORD;
      r_signed     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= 2'd0;
      r_data       <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_size   <= 2'b00;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_size      <= req_size;
            r_signed    <= req_signed;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_cnt       <= 2'd0;
            r_data      <= '0;
            r_req_ready <= 1'b0;
            if (req_size == SZ_ILL) begin
              // No memory access at all; report the error straight away.
              r_state      <= ST_DONE;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else if (is_aligned(req_size, req_addr[1:0])) begin
              r_state     <= ST_ONE;
              r_mem_read  <= ~req_write;
              r_mem_write <= req_write;
              r_mem_size  <= req_size;
              r_mem_addr  <= req_addr;
              r_mem_wdata <= req_wdata;
            end else begin
              // First byte of the split goes out in the cycle right after acceptance.
              r_state     <= ST_SPLIT;
              r_mem_read  <= ~req_write;
              r_mem_write <= req_write;
              r_mem_size  <= SZ_BYTE;
              r_mem_addr  <= req_addr;
              r_mem_wdata <= {24'b0, req_wdata[7:0]};
            end
          end
        end

        ST_ONE: begin
          r_state      <= ST_DONE;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= r_write ? 32'b0 : w_ext;
          r_mem_read   <= 1'b0;
          r_mem_write  <= 1'b0;
          r_mem_size   <= 2'b00;
          r_mem_addr   <= '0;
          r_mem_wdata  <= '0;
        end

        ST_SPLIT: begin
          r_data <= w_assembled;
          if (w_last) begin
            r_state      <= ST_DONE;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_write ? 32'b0 : w_ext;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_size   <= 2'b00;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
          end else begin
            // Address wraps naturally at ADDR_W bits.
            r_cnt       <= w_next_cnt;
            r_mem_addr  <= r_addr + ADDR_W'(w_next_cnt);
            r_mem_wdata <= {24'b0, byte_lane(r_wdata, w_next_cnt)};
          end
        end

        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
          r_req_ready  <= 1'b1;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_size   = r_mem_size;
  assign mem_signed = 1'b0;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-array memory model and a response scoreboard.
// Each request pushes its expected response and memory-op trace; both are checked on completion.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [32:0] exp_q   [$];   // {err, rdata}
  logic [18:0] exp_ops [$];   // {write, size, addr, wdata[7:0]}
  logic [18:0] ops     [$];

  logic [7:0] m [0:255];
  logic       do_preload;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_size   (mem_size),
    .mem_signed (mem_signed),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Memory: writes commit at the clock edge closing the op cycle.
  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < 256; i++) m[i] <= (i < 8) ? 8'(17 * (i + 1)) : 8'h00;
    end else if (mem_write) begin
      case (mem_size)
        2'b00: begin
          m[mem_addr]        <= mem_wdata[7:0];
          m[mem_addr + 8'd1] <= mem_wdata[15:8];
          m[mem_addr + 8'd2] <= mem_wdata[23:16];
          m[mem_addr + 8'd3] <= mem_wdata[31:24];
        end
        2'b01: begin
          m[mem_addr]        <= mem_wdata[7:0];
          m[mem_addr + 8'd1] <= mem_wdata[15:8];
        end
        default: m[mem_addr] <= mem_wdata[7:0];
      endcase
    end
  end

  always_comb begin
    mem_rdata = 32'h0;
    case (mem_size)
      2'b00:   mem_rdata = {m[mem_addr + 8'd3], m[mem_addr + 8'd2], m[mem_addr + 8'd1], m[mem_addr]};
      2'b01:   mem_rdata = {16'h0, m[mem_addr + 8'd1], m[mem_addr]};
      default: mem_rdata = {24'h0, m[mem_addr]};
    endcase
  end

  // Op trace monitor.
  always @(negedge clk) begin
    if (mem_read || mem_write) ops.push_back({mem_write, mem_size, mem_addr, mem_wdata[7:0]});
  end

  function automatic logic [18:0] op(input logic w, input logic [1:0] sz, input logic [7:0] a, input logic [7:0] wb);
    return {w, sz, a, wb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ops(input string tag);
    chk({tag, "_nops"}, ops.size(), exp_ops.size());
    for (int i = 0; i < exp_ops.size() && i < ops.size(); i++)
      chk($sformatf("%s_op%0d", tag, i), 32'(ops[i]), 32'(exp_ops[i]));
    exp_ops.delete();
  endtask

  task automatic preload();
    @(negedge clk);
    do_preload = 1'b1;
    @(negedge clk);
    do_preload = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [7:0] ad, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int lat;
    logic [32:0] e;
    @(negedge clk);
    ops.delete();
    exp_q.push_back({exp_err, exp_rd});
    chk({tag, "_ready_idle"}, req_ready, 1);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ad;
    req_wdata  = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = 32'h0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_resp_valid"}, resp_valid, 1);
    e = exp_q.pop_front();
    chk({tag, "_rdata"}, resp_rdata, e[31:0]);
    chk({tag, "_err"}, resp_err, e[32]);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_ready_done"}, req_ready, 0);
    @(negedge clk);
    chk({tag, "_pulse"}, resp_valid, 0);
    chk_ops(tag);
  endtask

  initial begin
    bit seen;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 8'h0;
    req_wdata  = 32'h0;
    do_preload = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_preload = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_rd", mem_read, 0);
    chk("rst_mem_wr", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_signed", mem_signed, 0);
    rst = 1'b0;

    exp_ops.push_back(op(0, 2'b00, 8'h04, 8'h00));
    do_req("lw4", 0, 2'b00, 0, 8'h04, 0, 32'h88776655, 0, 2);

    for (int i = 0; i < 4; i++) exp_ops.push_back(op(0, 2'b10, 8'(1 + i), 8'h00));
    do_req("lw1", 0, 2'b00, 0, 8'h01, 0, 32'h55443322, 0, 5);

    exp_ops.push_back(op(0, 2'b10, 8'h07, 8'h00));
    do_req("lb7", 0, 2'b10, 1, 8'h07, 0, 32'hFFFFFF88, 0, 2);
    exp_ops.push_back(op(0, 2'b10, 8'h07, 8'h00));
    do_req("lbu7", 0, 2'b10, 0, 8'h07, 0, 32'h00000088, 0, 2);
    exp_ops.push_back(op(0, 2'b01, 8'h06, 8'h00));
    do_req("lh6", 0, 2'b01, 1, 8'h06, 0, 32'hFFFF8877, 0, 2);

    exp_ops.push_back(op(0, 2'b10, 8'h05, 8'h00));
    exp_ops.push_back(op(0, 2'b10, 8'h06, 8'h00));
    do_req("lh5", 0, 2'b01, 1, 8'h05, 0, 32'h00007766, 0, 3);

    exp_ops.push_back(op(1, 2'b10, 8'hFE, 8'hEF));
    exp_ops.push_back(op(1, 2'b10, 8'hFF, 8'hBE));
    exp_ops.push_back(op(1, 2'b10, 8'h00, 8'hAD));
    exp_ops.push_back(op(1, 2'b10, 8'h01, 8'hDE));
    do_req("swFE", 1, 2'b00, 0, 8'hFE, 32'hDEADBEEF, 32'h0, 0, 5);
    chk("swFE_mFE", m[8'hFE], 8'hEF);
    chk("swFE_m01", m[8'h01], 8'hDE);

    for (int i = 0; i < 4; i++) exp_ops.push_back(op(0, 2'b10, 8'(8'hFE + i), 8'h00));
    do_req("lwFE", 0, 2'b00, 0, 8'hFE, 0, 32'hDEADBEEF, 0, 5);

    exp_ops.push_back(op(1, 2'b00, 8'h08, 8'h0D));
    do_req("sw8", 1, 2'b00, 0, 8'h08, 32'hCAFEF00D, 32'h0, 0, 2);
    exp_ops.push_back(op(0, 2'b01, 8'h0A, 8'h00));
    do_req("lhu10", 0, 2'b01, 0, 8'h0A, 0, 32'h0000CAFE, 0, 2);

    do_req("illegal", 0, 2'b11, 1, 8'h04, 0, 32'h0, 1, 1);

    // Reset in the third byte-write of a split store.
    preload();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 8'hFE; req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstsplit_wr_active", mem_write, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstsplit_mem_wr", mem_write, 0);
    chk("rstsplit_mem_rd", mem_read, 0);
    chk("rstsplit_ready", req_ready, 1);
    chk("rstsplit_resp", resp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("rstsplit_no_resp", 32'(seen), 0);
    chk("rstsplit_mFE", m[8'hFE], 8'hEF);
    chk("rstsplit_mFF", m[8'hFF], 8'hBE);
    chk("rstsplit_m00", m[8'h00], 8'h11);
    chk("rstsplit_m01", m[8'h01], 8'h22);

    exp_ops.push_back(op(0, 2'b00, 8'h00, 8'h00));
    do_req("lw0_after_rst", 0, 2'b00, 0, 8'h00, 0, 32'h44332211, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control unit between the execute stage and the byte-addressed data memory. Accepts one load or store request at a time over a valid/ready handshake and drives the memory's read/write/size/address/data controls. Aligned accesses go to memory as a single operation. Misaligned word/half accesses are split into byte operations, and the result is assembled. The unit performs all load sign/zero extension itself and returns one response per request.

## Interface
- ADDR_W, default 8: byte address width; all address arithmetic wraps modulo 2^ADDR_W.
- clk  in  1  clock. One clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 word, 01 half, 10 byte, 11 illegal.
- req_signed  in  1  sign-extend the load result; ignored for stores.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, little-endian.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  illegal size; valid with resp_valid.
- mem_read, mem_write  out  1  memory strobes.
- mem_size  out  2  same encoding as req_size.
- mem_signed  out  1  always 0.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  combinational memory read data, valid in the same cycle as mem_read.

## Operation
- **States:** IDLE, ONE, SPLIT, DONE.
- **IDLE:** req_ready=1, all mem_* outputs 0. When req_valid=1, latch all req_* fields.
  - size 11 -> DONE with err set.
  - Aligned access -> ONE. Aligned means word with addr[1:0]==0, half with addr[0]==0, or any byte.
  - Otherwise -> SPLIT with cnt=0.
- **ONE:**
  - Drive mem_size = latched size and mem_addr = latched addr.
  - mem_read = !write; mem_write = write.
  - mem_wdata = wdata.
  - Capture mem_rdata at the end of the cycle. Next state: DONE.
- **SPLIT:**
  - nbytes = 4 (word) or 2 (half).
  - Drive mem_size=10 and mem_addr = addr+cnt (wrapping).
  - mem_wdata = {24'b0, wdata[8*cnt+7:8*cnt]}.
  - A load captures mem_rdata[7:0] into byte lane cnt.
  - cnt increments each cycle. After cnt==nbytes-1 -> DONE.
- **DONE:** resp_valid=1, then -> IDLE. req_ready=0 in every state except IDLE.
- **Extension:**
  - Word: no extension.
  - Half: bits[31:16] = signed ? bit15 : 0.
  - Byte: bits[31:8] = signed ? bit7 : 0.
  - Stores return resp_rdata=0.
- **Reset:** all outputs 0 except req_ready=1; state IDLE, cnt=0, latches cleared.
  - Reset mid-SPLIT drops mem_write/mem_read immediately (async) and produces no response.
  - Bytes already written remain in memory.

## Timing
- Request accepted at edge E0.
- Aligned access: memory op in cycle E0..E1; resp_valid in cycle E1..E2. Two-cycle latency.
- Misaligned half: 2 op cycles, resp_valid at cycle 3.
- Misaligned word: 4 op cycles, resp_valid at cycle 5.
- Illegal size: resp_valid in the cycle after acceptance; no memory strobes.
- Back-to-back requests: next acceptance no earlier than the cycle after DONE (IDLE).
- mem_* outputs are registered state decodes, stable for a full clk cycle.
- One memory op per cycle; the memory commits a write within that cycle.

## Structure
- Shared package `lsu_pkg`:
  - size encodings SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10;
  - lsu_state_t enum;
  - function `is_aligned(size, addr)`.
- Sub-module `lsu_load_extend`: combinational assembled-data + size + signed -> 32-bit result. Shared with any future cache path.

## Test plan
Memory-relative bytes 0..7 are preloaded with 11,22,33,44,55,66,77,88 (hex).
- **Aligned word load:** lw addr 4 -> one cycle with mem_read=1, mem_size=00, mem_addr=4. resp_valid at cycle 2 with rdata 0x88776655.
- **Misaligned word load:** lw addr 1 -> byte reads at 1,2,3,4 on consecutive cycles. resp at cycle 5 with rdata 0x55443322, err=0.
- **Byte extension:** lb addr 7 -> 0xFFFFFF88. lbu addr 7 -> 0x00000088. lh addr 6 -> 0xFFFF8877.
- **Misaligned store with wrap:** sw addr 0xFE, data 0xDEADBEEF -> byte writes EF@FE, BE@FF, AD@00, DE@01. Readback lw addr 0xFE -> 0xDEADBEEF.
- **Reset mid-split:** assert rst after 2 byte writes of the store above -> mem_write=0 immediately, req_ready=1, no resp_valid. Bytes FE/FF updated, 00/01 unchanged.
- **Illegal size:** req_size=11 -> no mem_read/mem_write. resp_valid with resp_err=1 and rdata 0 in the cycle after acceptance.
